// File: rtl/ir_rate_detector.sv
`default_nettype none
// ============================================================================
// Module   : ir_rate_detector
// Purpose  : Multi-channel IR pulse-rate detector. Each channel counts
//            synchronised rising edges over a shared window and flags rate.
//            Optional macro IR_HYST_EN adds per-channel mode hysteresis.
// Revision : 1.0 - initial release
// ============================================================================
module ir_rate_detector #(
  parameter int CHANNELS    = 4,
  parameter int WINDOW      = 2000,
  parameter int CNT_W       = 10,
  parameter int THRESH      = 7,
  parameter int THRESH_LO   = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [CHANNELS-1:0]       detect_pin,
  output logic [CHANNELS-1:0]       mode,
  output logic [CHANNELS*CNT_W-1:0] last_count,
  output logic                      window_done
);

  localparam int             WIN_W      = $clog2(WINDOW);
  localparam logic [WIN_W-1:0] c_win_last = WIN_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] c_cnt_max  = {CNT_W{1'b1}};

  if (WINDOW < 2) begin : g_chk_window
    $error("WINDOW must be at least 2");
  end
  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (THRESH_LO > THRESH) begin : g_chk_thresh
    $error("THRESH_LO must not exceed THRESH");
  end

  logic [CHANNELS-1:0]       sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0]       sync_d [SYNC_STAGES];
  logic [CHANNELS-1:0]       prev_q, prev_d;
  logic [CHANNELS-1:0]       rise_q, rise_d;
  logic [WIN_W-1:0]          win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0]          edge_cnt_q [CHANNELS];
  logic [CNT_W-1:0]          edge_cnt_d [CHANNELS];
  logic [CNT_W-1:0]          fin_cnt    [CHANNELS];
  logic [CHANNELS-1:0]       mode_q, mode_d;
  logic [CHANNELS*CNT_W-1:0] last_count_q, last_count_d;
  logic                      window_done_q, window_done_d;
  logic                      win_close;

  // Synchroniser chain, then a registered rising-edge pulse per channel.
  always_comb begin
    sync_d[0] = detect_pin;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
    prev_d = sync_q[SYNC_STAGES-1];
    rise_d = sync_q[SYNC_STAGES-1] & ~prev_q;
  end

  always_comb begin
    win_close = enable && (win_cnt_q == c_win_last);
    win_cnt_d = win_cnt_q + 1'b1;
    if (!enable || win_close) begin
      win_cnt_d = '0;
    end
    window_done_d = win_close;
  end

  always_comb begin
    mode_d       = mode_q;
    last_count_d = last_count_q;
    for (int i = 0; i < CHANNELS; i++) begin
      // The edge seen in the closing cycle still belongs to this window.
      fin_cnt[i] = edge_cnt_q[i];
      if (enable && rise_q[i] && (edge_cnt_q[i] != c_cnt_max)) begin
        fin_cnt[i] = edge_cnt_q[i] + 1'b1;
      end
      edge_cnt_d[i] = (enable && !win_close) ? fin_cnt[i] : '0;
      if (win_close) begin
        last_count_d[i*CNT_W +: CNT_W] = fin_cnt[i];
`ifdef IR_HYST_EN
        if (int'(fin_cnt[i]) >= THRESH) begin
          mode_d[i] = 1'b1;
        end else if (int'(fin_cnt[i]) < THRESH_LO) begin
          mode_d[i] = 1'b0;
        end
`else
        mode_d[i] = (int'(fin_cnt[i]) >= THRESH);
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      for (int i = 0; i < CHANNELS; i++) begin
        edge_cnt_q[i] <= '0;
      end
      prev_q        <= '0;
      rise_q        <= '0;
      win_cnt_q     <= '0;
      mode_q        <= '0;
      last_count_q  <= '0;
      window_done_q <= 1'b0;
    end else begin
      sync_q        <= sync_d;
      edge_cnt_q    <= edge_cnt_d;
      prev_q        <= prev_d;
      rise_q        <= rise_d;
      win_cnt_q     <= win_cnt_d;
      mode_q        <= mode_d;
      last_count_q  <= last_count_d;
      window_done_q <= window_done_d;
    end
  end

  assign mode        = mode_q;
  assign last_count  = last_count_q;
  assign window_done = window_done_q;

endmodule
`default_nettype wire
